// File: rtl/dk_sequencer.sv
// Five-state control sequencer for a yk-1 / Kd derivative datapath (diff -> mul -> trunc -> dk).
// Optional first-sample priming is enabled with the DK_PRIME_EN macro.
module dk_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        en1,
  output logic        en2,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] sample_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIFF  = 3'd1,
    MUL   = 3'd2,
    TRUNC = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   primed;
  logic   busy_next;

`ifdef DK_PRIME_EN
  // Cleared by reset; set when the first (priming) sequence leaves DONE.
  logic prime_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_flag <= 1'b0;
    end else if (state == DONE) begin
      prime_flag <= 1'b1;
    end
  end

  assign primed = prime_flag;
`else
  assign primed = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIFF;
      DIFF:    state_next = MUL;
      MUL:     state_next = TRUNC;
      TRUNC:   state_next = DONE;
      DONE:    state_next = start ? DIFF : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next == DIFF) || (state_next == MUL) || (state_next == TRUNC);

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they describe while staying free of any path from start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      en1        <= 1'b0;
      en2        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= 16'h0000;
    end else begin
      state   <= state_next;
      en1     <= (state_next == DIFF);
      en2     <= (state_next == TRUNC) && primed;
      busy    <= busy_next;
      done    <= (state_next == DONE);
      overrun <= start && busy;
      if ((state == DONE) && primed && (sample_cnt != 16'hFFFF)) begin
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/dk_sequencer.md
DK_SEQUENCER -- requirements
Module: dk_sequencer

Interface
REQ-001 SHALL have no parameters; all widths are fixed as stated below.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle strobe; yk at the derivative datapath input is valid in this cycle.
REQ-005 en1  output  1  enable for the previous-sample (yk-1) register of the derivative datapath.
REQ-006 en2  output  1  enable for the dk output register of the derivative datapath.
REQ-007 busy  output  1  high while a sequence is in progress and a start would be rejected.
REQ-008 done  output  1  one-cycle pulse; the new dk is valid in this cycle.
REQ-009 overrun  output  1  one-cycle pulse; a start was rejected.
REQ-010 sample_cnt  output  16  number of completed sequences; saturates at 16'hFFFF.

Function
REQ-011 SHALL implement a five-state machine: IDLE, DIFF, MUL, TRUNC, DONE.
REQ-012 IDLE -> DIFF on the edge that samples start=1; otherwise IDLE holds.
REQ-013 DIFF -> MUL -> TRUNC -> DONE on consecutive edges, unconditionally.
REQ-014 DONE -> DIFF if start=1 on that edge; otherwise DONE -> IDLE.
REQ-015 en1 SHALL be 1 only in DIFF, so the yk-1 register loads on the same edge on which the difference register samples the old difference.
REQ-016 en2 SHALL be 1 only in TRUNC, so the dk register loads the truncated product on the edge into DONE.
REQ-017 done SHALL be 1 only in DONE; start in cycle 0 -> en1 in cycle 1, en2 in cycle 3, done in cycle 4.
REQ-018 yk SHALL be required stable only in the start cycle; the sequencer places no hold requirement after that cycle.
REQ-019 busy SHALL be 1 in DIFF, MUL and TRUNC, and 0 in IDLE and DONE.
REQ-020 start while busy=1 SHALL be ignored: the state is unaffected, en1/en2 are unaffected, and overrun=1 in the following cycle.
REQ-021 Maximum accepted start rate SHALL be one per 4 cycles (start in a DONE cycle is accepted).
REQ-022 sample_cnt SHALL increment by 1 on each edge leaving DONE, and hold at 16'hFFFF.
REQ-023 en1, en2, done and overrun SHALL be registered outputs, with no combinational path from start.

Reset
REQ-024 Reset SHALL force the state to IDLE and drive en1=0, en2=0, busy=0, done=0, overrun=0, sample_cnt=0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence with no en2 or done pulse; the next start after release begins a full sequence.
REQ-026 Reset SHALL re-arm the priming flag described in REQ-027.

Configuration
REQ-027 With DK_PRIME_EN defined: the first accepted sequence after reset runs normally except that en2 stays 0; done still pulses, sample_cnt is not incremented, and a prime flag is set so that later sequences assert en2; this prevents the first dk from equalling Kd*yk against a zeroed yk-1.
REQ-028 Without DK_PRIME_EN: every sequence, including the first after reset, asserts en2 in TRUNC and increments sample_cnt.

Verification
REQ-029 Reset, then start at cycle 0 -> en1=1 at cycle 1, en2=1 at cycle 3, done=1 at cycle 4, sample_cnt=1, busy=1 in cycles 1-3 only.
REQ-030 Starts at cycles 0, 4 and 8 -> three back-to-back sequences with en2 at cycles 3, 7 and 11; overrun never asserts; sample_cnt=3.
REQ-031 Start at cycle 0 and again at cycle 2 -> overrun=1 at cycle 3, exactly one en2 pulse (cycle 3), sample_cnt=1.
REQ-032 Reset asserted at cycle 2 of a sequence -> outputs go to 0 at once, no done pulse; a start after release gives done 4 cycles later.
REQ-033 With DK_PRIME_EN and Kd=150, samples yk=10 then yk=14 -> no en2 on the first sequence, dk stays 0; second sequence gives dk equal to the truncation of 600 (4*150); sample_cnt=1.
REQ-034 Force sample_cnt to 16'hFFFE, then run 3 sequences -> sample_cnt=16'hFFFF and stays there.
